mux_rr_sched: RTL and testbench
===============================

Name: mux_rr_sched

Overview:
- Round-robin scheduler that shares one 8:1 serial data path between 8 requesters.
- Arbitrates `req_in[7:0]` and drives the 3-bit select for the shared 8:1 selector.
- Grants the path in bursts of up to `BURST_LEN` cycles.
- Outputs a registered copy of the selected data line.
- Sits between the requester bank and the downstream single-bit consumer.

Parameters:
- `BURST_LEN`, default 4: maximum grant length in cycles. Legal range 1..15.
- `CNT_W`, default 4: width of the burst counter. Must satisfy 2^CNT_W > BURST_LEN.

Ports:
- `clk_in`  input  1  system clock; all state updates on the rising edge.
- `rst_in`  input  1  reset, asynchronous, active-high.
- `en_in`  input  1  scheduler enable. Low means no new grants and the current grant is terminated.
- `req_in`  input  8  request per requester; bit i = requester i.
- `d_in`  input  8  data line per requester.
- `sel_out`  output  3  binary index of the granted requester; drives the shared selector.
- `gnt_out`  output  8  one-hot grant; all zero when idle.
- `busy_out`  output  1  high while a grant is active.
- `y_out`  output  1  registered `d_in[sel_out]`.

Behaviour:
- Interface: one clock, `clk_in`. Reset `rst_in` is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - `sel_out` = 0, `gnt_out` = 0, `busy_out` = 0, `y_out` = 0.
  - Internal burst counter = 0.
  - Round-robin pointer `ptr` = 7, so the first search starts at index 0.
- Reset asserted mid-grant clears everything immediately, with no clock needed.
- Pick function (combinational):
  - Search `req_in` starting at index `ptr`+1, modulo 8, wrapping through `ptr` itself.
  - The first set bit wins.
  - The last-served requester therefore has lowest priority but can win again if it is the only requester.
- State IDLE:
  - Condition: `en_in` && |`req_in` at a clock edge.
  - Action: `sel_out` <= pick, `gnt_out` <= one-hot(pick), `busy_out` <= 1, counter <= `BURST_LEN`-1, go to GRANT.
  - Latency from request to grant is 1 cycle.
  - Otherwise stay in IDLE with outputs unchanged, except `y_out` <= 0.
- State GRANT, every edge:
  - `y_out` <= `d_in[sel_out]`. `y_out` therefore lags `sel_out` by one cycle.
  - Non-selected `d_in` bits have no effect.
- Grant termination, evaluated at each edge in GRANT. The grant ends if any of:
  - counter == 0;
  - `req_in[sel_out]` == 0;
  - `en_in` == 0.
- Otherwise the counter decrements.
- On termination:
  - `ptr` <= `sel_out`.
  - If `en_in` && |`req_in`: re-grant in the same edge using pick computed with the new `ptr` (search from `sel_out`+1). No idle bubble; counter reloads to `BURST_LEN`-1.
  - Else: go to IDLE with `gnt_out` <= 0 and `busy_out` <= 0. `sel_out` holds its last value.
- Grant length: a held request receives exactly `BURST_LEN` consecutive cycles of `gnt_out`.
- `BURST_LEN` = 1: re-arbitration every cycle, giving a strict rotating grant.
- Simultaneous drop of the current request with a new request elsewhere resolves in the same edge to the new requester.
- Invariants:
  - `gnt_out` is always zero or one-hot.
  - When `busy_out` = 1, `gnt_out` == one-hot(`sel_out`).
  - Requests arriving mid-burst never pre-empt the current grant.

Decomposition:
- Shared package / include holds:
  - state encoding constants `ST_IDLE` = 1'b0 and `ST_GRANT` = 1'b1;
  - `N_REQ` = 8;
  - `SEL_W` = 3.
- Sub-module `rr_pick8` (combinational):
  - Inputs: `req[7:0]`, `ptr[2:0]`.
  - Outputs: `idx[2:0]`, `found`.
  - Implementation: rotate-and-priority-encode.
- Instantiate `rr_pick8` twice:
  - one with the stored `ptr`, used for the IDLE grant;
  - one with `sel_out`, used for the back-to-back re-grant.
- Top holds the FSM, counter, pointer and output registers.

Test Plan:
1. Reset mid-grant:
   - Stimulus: `req_in`=8'h10, grant active; assert `rst_in` between edges.
   - Response: `gnt_out`, `busy_out`, `sel_out` and `y_out` are 0 immediately. After release with `req_in`=8'hFF, the first grant goes to index 0.
2. Single continuous requester:
   - Stimulus: `req_in`=8'h08, `BURST_LEN`=4.
   - Response: grant appears 1 cycle later with `gnt_out`=8'h08 and `sel_out`=3. `busy_out` stays high continuously; re-grants occur every 4 cycles with no gap.
3. Full round robin:
   - Stimulus: `req_in`=8'hFF from reset.
   - Response: `sel_out` sequence 0,1,2,…,7,0, each held for exactly 4 cycles, with no idle cycles.
4. Early release:
   - Stimulus: `req_in`=8'h05; granted to 0; drop `req_in[0]` after 2 grant cycles.
   - Response: the next edge grants index 2 (`gnt_out`=8'h04) with the counter reloaded.
5. Wrap and fairness:
   - Stimulus: current grant at 6, `req_in`=8'h41.
   - Response: after the burst, `sel_out`=0 (not 6). After 0's burst, `sel_out`=6.
6. Data path and enable:
   - Stimulus: grant at `sel_out`=5, `d_in`=8'h20; toggle `d_in[4]`.
   - Response: `y_out`=1 one cycle later, unaffected by `d_in[4]`. Dropping `en_in` ends the grant at the next edge: `busy_out`=0, `gnt_out`=0, `y_out`=0 the following cycle.

Source files
------------

// File: rtl/mux_rr_sched_pkg.sv
// Shared definitions for the round-robin serial-path scheduler.
package mux_rr_sched_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // One-hot decode of a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux_rr_sched_rr_pick8.sv
// Combinational round-robin pick: first set request searching upward from ptr+1, wrapping.
module rr_pick8
  import mux_rr_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0]   start;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;

  assign start   = ptr + SEL_W'(1);
  assign req_dbl = {req, req};
  // Bit k of req_rot is requester (start + k) mod 8.
  assign req_rot = req_dbl[start +: N_REQ];

  // Priority-encode the rotated vector; lowest set bit wins, so scan downward.
  always_comb begin
    found = 1'b0;
    idx   = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        found = 1'b1;
        idx   = start + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin burst scheduler sharing one 8:1 serial data path among 8 requesters.
module mux_rr_sched
  import mux_rr_sched_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] d_in,
  output logic [SEL_W-1:0] sel_out,
  output logic [N_REQ-1:0] gnt_out,
  output logic             busy_out,
  output logic             y_out
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BURST_LEN - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             y_q, y_d;

  logic [SEL_W-1:0] idle_idx, next_idx;
  logic             idle_found, next_found;
  logic             terminate;

  // Fresh grant out of idle searches from the stored pointer.
  rr_pick8 u_pick_idle (
    .req   (req_in),
    .ptr   (ptr_q),
    .idx   (idle_idx),
    .found (idle_found)
  );

  // Back-to-back re-grant searches from the requester just finishing.
  rr_pick8 u_pick_next (
    .req   (req_in),
    .ptr   (sel_q),
    .idx   (next_idx),
    .found (next_found)
  );

  assign terminate = (cnt_q == '0) || !req_in[sel_q] || !en_in;

  // Next-state logic: grant from idle, burst countdown, termination and re-grant.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    y_d     = y_q;
    unique case (state_q)
      ST_IDLE: begin
        y_d = 1'b0;
        if (en_in && idle_found) begin
          state_d = ST_GRANT;
          sel_d   = idle_idx;
          gnt_d   = onehot(idle_idx);
          busy_d  = 1'b1;
          cnt_d   = CNT_RELOAD;
        end
      end
      ST_GRANT: begin
        y_d = d_in[sel_q];
        if (terminate) begin
          ptr_d = sel_q;
          if (en_in && next_found) begin
            sel_d = next_idx;
            gnt_d = onehot(next_idx);
            cnt_d = CNT_RELOAD;
          end else begin
            // sel_out deliberately holds its last value while idle.
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  // State and output registers; pointer resets to 7 so the first search starts at 0.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      ptr_q   <= SEL_W'(N_REQ - 1);
      cnt_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      y_q     <= y_d;
    end
  end

  assign sel_out  = sel_q;
  assign gnt_out  = gnt_q;
  assign busy_out = busy_q;
  assign y_out    = y_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Self-checking bench for mux_rr_sched: directed test-plan steps plus a randomized phase,
// all checked against a burst-level reference model of the scheduling rules.
module tb_mux_rr_sched;

  localparam int BURST = 4;

  logic       clk_in;
  logic       rst_in;
  logic       en_in;
  logic [7:0] req_in;
  logic [7:0] d_in;
  logic [2:0] sel_out;
  logic [7:0] gnt_out;
  logic       busy_out;
  logic       y_out;

  int n_assert;
  int n_fail;

  // Reference model: who owns the path, how many cycles it has had, last served index.
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_served;
  bit m_y;

  mux_rr_sched #(
    .BURST_LEN (BURST),
    .CNT_W     (4)
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en_in    (en_in),
    .req_in   (req_in),
    .d_in     (d_in),
    .sel_out  (sel_out),
    .gnt_out  (gnt_out),
    .busy_out (busy_out),
    .y_out    (y_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First requester at or after p+1 (mod 8), wrapping through p itself.
  function automatic int rr_pick(input int p, input logic [7:0] r);
    for (int k = 1; k <= 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy   = 0;
    m_sel    = 0;
    m_ptr    = 7;
    m_served = 0;
    m_y      = 0;
  endtask

  // Apply the scheduling rules for one clock edge using the current inputs.
  task automatic model_edge();
    if (!m_busy) begin
      m_y = 0;
      if (en_in && req_in != 0) begin
        m_sel    = rr_pick(m_ptr, req_in);
        m_busy   = 1;
        m_served = 1;
      end
    end else begin
      m_y = d_in[m_sel];
      if (m_served >= BURST || !req_in[m_sel] || !en_in) begin
        m_ptr = m_sel;
        if (en_in && req_in != 0) begin
          m_sel    = rr_pick(m_ptr, req_in);
          m_served = 1;
        end else begin
          m_busy = 0;
        end
      end else begin
        m_served++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] exp_gnt;
    exp_gnt = m_busy ? (8'h01 << m_sel) : 8'h00;
    chk({tag, ".sel"}, {5'd0, sel_out}, 8'(m_sel));
    chk({tag, ".gnt"}, gnt_out, exp_gnt);
    chk({tag, ".busy"}, {7'd0, busy_out}, {7'd0, m_busy});
    chk({tag, ".y"}, {7'd0, y_out}, {7'd0, m_y});
  endtask

  // One clock: update the model from pre-edge inputs, then sample 1 time unit after the edge.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk_in);
    #1;
    check_model(tag);
  endtask

  // Assert reset between edges; outputs must clear without any clock edge.
  task automatic do_reset(input string tag);
    #2;
    rst_in = 1'b1;
    #1;
    model_reset();
    chk({tag, ".rst_gnt"}, gnt_out, 8'h00);
    chk({tag, ".rst_busy"}, {7'd0, busy_out}, 8'h00);
    chk({tag, ".rst_sel"}, {5'd0, sel_out}, 8'h00);
    chk({tag, ".rst_y"}, {7'd0, y_out}, 8'h00);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_in   = 1'b1;
    en_in    = 1'b0;
    req_in   = 8'h00;
    d_in     = 8'h00;
    model_reset();
    @(posedge clk_in);
    #1;
    check_model("reset");
    rst_in = 1'b0;

    // Single continuous requester: grant after one edge, seamless 4-cycle re-grants.
    en_in  = 1'b1;
    req_in = 8'h08;
    step("single");
    chk("single.gnt_first", gnt_out, 8'h08);
    chk("single.sel_first", {5'd0, sel_out}, 8'd3);
    for (int i = 0; i < 12; i++) begin
      step("single_hold");
      chk("single.busy_hold", {7'd0, busy_out}, 8'd1);
    end

    // Full round robin from reset: 0,1,...,7,0 each for exactly 4 cycles.
    do_reset("rr");
    req_in = 8'hFF;
    for (int i = 0; i < 36; i++) begin
      step("rr");
      chk("rr.sel_seq", {5'd0, sel_out}, 8'((i / BURST) % 8));
    end

    // Reset mid-grant, then the first grant after release goes to index 0.
    do_reset("midpre");
    req_in = 8'h10;
    step("mid");
    step("mid");
    do_reset("mid");
    req_in = 8'hFF;
    step("mid_after");
    chk("mid.first_sel", {5'd0, sel_out}, 8'd0);

    // Early release: dropping requester 0 hands the path to 2 on the next edge.
    do_reset("early");
    req_in = 8'h05;
    step("early");
    step("early");
    req_in = 8'h04;
    step("early_drop");
    chk("early.gnt", gnt_out, 8'h04);
    for (int i = 0; i < 5; i++) step("early_tail");

    // Wrap and fairness: 6 then 0 then 6.
    do_reset("wrap");
    req_in = 8'h40;
    step("wrap");
    req_in = 8'h41;
    for (int i = 0; i < BURST; i++) step("wrap");
    chk("wrap.to0", {5'd0, sel_out}, 8'd0);
    for (int i = 0; i < BURST; i++) step("wrap");
    chk("wrap.to6", {5'd0, sel_out}, 8'd6);

    // Data path and enable.
    do_reset("data");
    req_in = 8'h20;
    d_in   = 8'h20;
    step("data");
    chk("data.sel", {5'd0, sel_out}, 8'd5);
    d_in = 8'h30;
    step("data");
    chk("data.y1", {7'd0, y_out}, 8'd1);
    d_in = 8'h20;
    step("data");
    chk("data.y2", {7'd0, y_out}, 8'd1);
    en_in = 1'b0;
    step("data_off");
    chk("data.off_busy", {7'd0, busy_out}, 8'd0);
    chk("data.off_gnt", gnt_out, 8'h00);
    step("data_off2");
    chk("data.off_y", {7'd0, y_out}, 8'd0);

    // Randomized traffic against the model, including occasional mid-cycle resets.
    do_reset("rand");
    for (int i = 0; i < 400; i++) begin
      en_in  = ($urandom_range(0, 9) != 0);
      req_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : req_in;
      if ($urandom_range(0, 15) == 0) req_in[sel_out] = 1'b0;
      d_in   = 8'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset("rand");
      else step("rand");
      chk("rand.onehot", {7'd0, ($countones(gnt_out) <= 1)}, 8'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
